ahb_bus_arbiter: RTL
====================

// Module: ahb_bus_arbiter
// PURPOSE
//  Arbiter for the shared AHB address/control/write-data bus between 5 masters.
//  Samples per-master bus requests and lock signals, and issues one-hot HGRANTx.
//  Drives HMASTER[3:0], which selects the address/control mux directly and,
//  after one HREADY-qualified cycle, the write-data mux. Also drives HMASTLOCK.
//  Round-robin priority. Fixed-length bursts are never broken; undefined INCR
//  bursts are capped.
// PARAMETERS
//  DEFAULT_MASTER  0   master granted when no request is pending; reset owner (0..4)
//  INCR_LIMIT      16  beats an undefined-length INCR burst keeps the bus when others request (>=2)
// PORTS
//  CLK        in   1  single bus clock; all state on rising edge
//  RESETn     in   1  asynchronous, active-low reset
//  HBUSREQ0-4 in   1  bus request, master 0..4
//  HLOCK0-4   in   1  locked-transfer request, master 0..4
//  HTRANS     in   2  muxed HTRANS of current address-phase owner (IDLE=00,BUSY=01,NONSEQ=10,SEQ=11)
//  HBURST     in   3  muxed HBURST (SINGLE=0,INCR=1,WRAP4=2,INCR4=3,WRAP8=4,INCR8=5,WRAP16=6,INCR16=7)
//  HREADY     in   1  slave-side transfer-complete
//  HGRANT0-4  out  1  registered one-hot grant, master 0..4
//  HMASTER    out  4  registered index of address-phase owner; values 0..4 only
//  HMASTLOCK  out  1  registered; current address phase is part of a locked sequence
// BEHAVIOUR
//  Reset (RESETn=0, async): HGRANT one-hot at DEFAULT_MASTER; HMASTER=DEFAULT_MASTER;
//   HMASTLOCK=0; beat counter rem=0; RR pointer=DEFAULT_MASTER.
//   Mid-burst reset abandons the burst with no resume state.
//  Beat counter rem = address beats still to issue, updated only on HREADY=1 edges:
//   NONSEQ -> rem=N-1, where N = 1/4/8/16 by HBURST and INCR gives INCR_LIMIT
//   SEQ -> rem=rem-1, saturating at 0
//   BUSY -> rem unchanged
//   IDLE -> rem=0 (early termination frees the bus)
//  arb_en = HREADY & ~lock_hold & (rem_next<=1), where rem_next is this edge's
//   updated rem. For SINGLE, arb_en is set on every HREADY edge.
//  lock_hold = HLOCKx of the currently granted master is 1.
//  On an arb_en edge, HGRANT is loaded with the winner:
//   search order HMASTER+1, +2, ... mod 5 over HBUSREQx; first requester wins
//   current owner is last in order, so it keeps the bus only if no one else asks
//   no requester -> DEFAULT_MASTER
//  When arb_en=0, HGRANT holds.
//  Grant change for an INCR4 burst lands during the last beat's address phase.
//  HMASTER <= index(HGRANT) and HMASTLOCK <= HLOCK[index(HGRANT)] on every
//   HREADY=1 edge; both hold while HREADY=0.
//  Wait states (HREADY=0): counter, grant and HMASTER all frozen.
//  Simultaneous requests are resolved only by RR order; no fixed priority.
//  A request dropped before arb_en is never granted.
//  HGRANT is always exactly one-hot.
//  HMASTER never takes codes 5..15.
// TESTING
//  T1 Reset mid-INCR8, HBUSREQ1=1: drive RESETn=0
//     -> same instant HGRANT0=1, HMASTER=0, HMASTLOCK=0; after release, master 1 granted at first HREADY edge.
//  T2 No requests for 20 cycles, HREADY=1, HTRANS=IDLE
//     -> HGRANT0 stays 1, HMASTER stays 0.
//  T3 Owner 0, HBUSREQ2 and HBUSREQ4 both rise, SINGLE transfers
//     -> master 2 granted first, then 4, then back to 0 if 0 requests;
//        HMASTER tracks each grant one HREADY edge later.
//  T4 Master 1 INCR4 with HBUSREQ3=1 and one HREADY=0 wait on beat 2
//     -> HGRANT3 rises on the edge accepting beat 3;
//        HMASTER=3 after the edge accepting beat 4; grant never moves during the wait.
//  T5 Master 1 holds HLOCK1 across two INCR4 bursts while HBUSREQ0=1
//     -> HGRANT1 held throughout, HMASTLOCK=1 for all 8 beats;
//        master 0 is granted after HLOCK1 falls.
//  T6 Master 2 runs INCR for 40 beats while HBUSREQ0=1, INCR_LIMIT=16
//     -> grant moves to master 0 after beat 15 is accepted; HMASTER=0 after beat 16.

Source files
------------

// File: rtl/ahb_bus_arbiter.sv
// Round-robin AHB bus arbiter for five masters. It never breaks fixed-length
// bursts, caps undefined INCR bursts at INCR_LIMIT beats, and honours locked sequences.
module ahb_bus_arbiter #(
    parameter int DEFAULT_MASTER = 0,
    parameter int INCR_LIMIT     = 16
) (
    input  logic       CLK,
    input  logic       RESETn,
    input  logic       HBUSREQ0,
    input  logic       HBUSREQ1,
    input  logic       HBUSREQ2,
    input  logic       HBUSREQ3,
    input  logic       HBUSREQ4,
    input  logic       HLOCK0,
    input  logic       HLOCK1,
    input  logic       HLOCK2,
    input  logic       HLOCK3,
    input  logic       HLOCK4,
    input  logic [1:0] HTRANS,
    input  logic [2:0] HBURST,
    input  logic       HREADY,
    output logic       HGRANT0,
    output logic       HGRANT1,
    output logic       HGRANT2,
    output logic       HGRANT3,
    output logic       HGRANT4,
    output logic [3:0] HMASTER,
    output logic       HMASTLOCK
);

    localparam int CNT_W = $clog2((INCR_LIMIT > 16) ? INCR_LIMIT : 16);

    localparam logic [1:0] TR_IDLE   = 2'b00;
    localparam logic [1:0] TR_BUSY   = 2'b01;
    localparam logic [1:0] TR_NONSEQ = 2'b10;
    localparam logic [1:0] TR_SEQ    = 2'b11;

    localparam logic [2:0] DEF_IDX = 3'(DEFAULT_MASTER);

    logic [4:0]       busreq;
    logic [4:0]       lock;
    logic [2:0]       grant_q;
    logic [2:0]       master_q;
    logic             mastlock_q;
    logic [CNT_W-1:0] rem_q;
    logic [CNT_W-1:0] rem_next;
    logic [2:0]       winner;
    logic             lock_hold;
    logic             arb_en;

    assign busreq = {HBUSREQ4, HBUSREQ3, HBUSREQ2, HBUSREQ1, HBUSREQ0};
    assign lock   = {HLOCK4, HLOCK3, HLOCK2, HLOCK1, HLOCK0};

    // Beats remaining after a NONSEQ; undefined-length INCR is treated as INCR_LIMIT beats.
    function automatic logic [CNT_W-1:0] burst_rem(input logic [2:0] burst);
        logic [CNT_W-1:0] r;
        case (burst)
            3'd0:       r = '0;
            3'd1:       r = CNT_W'(INCR_LIMIT - 1);
            3'd2, 3'd3: r = CNT_W'(3);
            3'd4, 3'd5: r = CNT_W'(7);
            default:    r = CNT_W'(15);
        endcase
        return r;
    endfunction

    function automatic logic [CNT_W-1:0] sat_dec(input logic [CNT_W-1:0] v);
        return (v == '0) ? '0 : v - CNT_W'(1);
    endfunction

    // The current owner is checked last, so it only keeps the bus if no one else asks.
    function automatic logic [2:0] pick_winner(input logic [2:0] base, input logic [4:0] req);
        logic [2:0] w;
        logic       found;
        w     = DEF_IDX;
        found = 1'b0;
        for (int i = 1; i <= 5; i++) begin
            int c;
            c = int'(base) + i;
            if (c >= 5) c = c - 5;
            if (!found && req[3'(c)]) begin
                w     = 3'(c);
                found = 1'b1;
            end
        end
        return w;
    endfunction

    always_comb begin
        rem_next = rem_q;
        case (HTRANS)
            TR_NONSEQ: rem_next = burst_rem(HBURST);
            TR_SEQ:    rem_next = sat_dec(rem_q);
            TR_BUSY:   rem_next = rem_q;
            TR_IDLE:   rem_next = '0;
            default:   rem_next = rem_q;
        endcase
    end

    assign lock_hold = lock[grant_q];
    assign arb_en    = HREADY && !lock_hold && (rem_next <= CNT_W'(1));
    assign winner    = pick_winner(master_q, busreq);

    always_ff @(posedge CLK or negedge RESETn) begin
        if (!RESETn) begin
            grant_q    <= DEF_IDX;
            master_q   <= DEF_IDX;
            mastlock_q <= 1'b0;
            rem_q      <= '0;
        end else if (HREADY) begin
            rem_q      <= rem_next;
            master_q   <= grant_q;
            mastlock_q <= lock[grant_q];
            if (arb_en) grant_q <= winner;
        end
    end

    assign HGRANT0   = (grant_q == 3'd0);
    assign HGRANT1   = (grant_q == 3'd1);
    assign HGRANT2   = (grant_q == 3'd2);
    assign HGRANT3   = (grant_q == 3'd3);
    assign HGRANT4   = (grant_q == 3'd4);
    assign HMASTER   = {1'b0, master_q};
    assign HMASTLOCK = mastlock_q;

endmodule
